// File: rtl/imem_loader_if.sv
// Byte-stream receive handshake plus the imem write port driven by the boot loader.
// The loader itself uses the slave view; whatever feeds it bytes uses the master view.
interface imem_loader_if #(
    parameter int ADDR_W = 6
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: header byte (word count), little-endian words,
// XOR checksum byte. Holds the core in reset until an image loads with a good checksum.
module imem_loader #(
    parameter int ADDR_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    imem_loader_if.slave    bus,
    output logic            core_reset,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic [ADDR_W:0] words_loaded
);
    localparam int CNT_W    = ADDR_W + 1;
    localparam int CAPACITY = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t            state_reg;
    state_t            state_next;

    logic [7:0]        csum_reg;
    logic [1:0]        byte_idx_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  words_loaded_reg;
    logic              imem_we_reg;
    logic [ADDR_W-1:0] imem_addr_reg;
    logic [31:0]       imem_wdata_reg;
    logic [23:0]       asm_word;

    logic              accept;
    logic              start_ok;
    logic              hdr_bad;
    logic              data_accept;
    logic              word_done;
    logic              last_word;

    assign bus.rx_ready = (state_reg == ST_HDR) || (state_reg == ST_DATA) || (state_reg == ST_CSUM);
    assign accept       = bus.rx_valid && bus.rx_ready;
    assign start_ok     = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE) || (state_reg == ST_ERROR));
    assign hdr_bad      = (bus.rx_data == 8'd0) || ({24'd0, bus.rx_data} > 32'(CAPACITY));
    assign data_accept  = accept && (state_reg == ST_DATA);
    assign word_done    = data_accept && (byte_idx_reg == 2'd3);
    assign last_word    = word_done && ((words_loaded_reg + CNT_W'(1)) == count_reg);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) state_next = ST_HDR;
            end
            ST_HDR: begin
                if (accept) state_next = hdr_bad ? ST_ERROR : ST_DATA;
            end
            ST_DATA: begin
                if (last_word) state_next = ST_CSUM;
            end
            ST_CSUM: begin
                if (accept) state_next = (bus.rx_data == csum_reg) ? ST_DONE : ST_ERROR;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Bytes 0..2 of a word park in their own lanes; byte 3 completes the word directly
    // into the write register, so the next word's bytes can arrive immediately.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            logic [7:0] lane_reg;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    lane_reg <= 8'd0;
                end else if (data_accept && (byte_idx_reg == 2'(gi))) begin
                    lane_reg <= bus.rx_data;
                end
            end
            assign asm_word[gi*8 +: 8] = lane_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum_reg         <= 8'd0;
            byte_idx_reg     <= 2'd0;
            count_reg        <= '0;
            words_loaded_reg <= '0;
            imem_we_reg      <= 1'b0;
            imem_addr_reg    <= '0;
            imem_wdata_reg   <= 32'd0;
        end else begin
            imem_we_reg <= 1'b0;
            if (start_ok) begin
                csum_reg         <= 8'd0;
                byte_idx_reg     <= 2'd0;
                words_loaded_reg <= '0;
            end
            if (accept && (state_reg == ST_HDR)) begin
                csum_reg  <= csum_reg ^ bus.rx_data;
                count_reg <= CNT_W'(bus.rx_data);
            end
            if (data_accept) begin
                csum_reg     <= csum_reg ^ bus.rx_data;
                byte_idx_reg <= byte_idx_reg + 2'd1;
            end
            if (word_done) begin
                imem_we_reg      <= 1'b1;
                imem_wdata_reg   <= {bus.rx_data, asm_word};
                imem_addr_reg    <= words_loaded_reg[ADDR_W-1:0];
                words_loaded_reg <= words_loaded_reg + CNT_W'(1);
            end
        end
    end

    // Status flags decode straight from the registered state.
    assign busy         = (state_reg == ST_HDR) || (state_reg == ST_DATA) || (state_reg == ST_CSUM);
    assign done         = (state_reg == ST_DONE);
    assign error        = (state_reg == ST_ERROR);
    assign core_reset   = (state_reg != ST_DONE);
    assign words_loaded = words_loaded_reg;

    assign bus.imem_we    = imem_we_reg;
    assign bus.imem_addr  = imem_addr_reg;
    assign bus.imem_wdata = imem_wdata_reg;
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: sessions are built from a word list, expected imem
// writes go into a queue, and an independent monitor pops them on every write pulse.
module tb_imem_loader;
    localparam int ADDR_W = 6;
    localparam int CAP    = 2 ** ADDR_W;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            core_reset;
    logic            busy;
    logic            done;
    logic            error;
    logic [ADDR_W:0] words_loaded;

    imem_loader_if #(.ADDR_W(ADDR_W)) ifc ();

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bus          (ifc),
        .core_reset   (core_reset),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] exp_words[$];
    logic [7:0]  stream[$];
    logic        exp_valid;
    logic        exp_done;
    int          exp_wl;
    int          checks = 0;
    int          errors = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Scoreboard monitor: every write pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (ifc.imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0d data %08h with nothing expected", ifc.imem_addr, ifc.imem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 64'(ifc.imem_addr), 64'(e.addr));
                check("wr_data", 64'(ifc.imem_wdata), 64'(e.data));
                $display("write addr %0d data %08h (expected %0d %08h)", ifc.imem_addr, ifc.imem_wdata, e.addr, e.data);
            end
        end
    end

    // Reference model: byte stream and outcome derived from header, word list and checksum flag.
    task automatic build_session(input logic [7:0] hdr, input logic csum_ok);
        logic [7:0] cs;
        stream.delete();
        stream.push_back(hdr);
        exp_valid = (hdr != 8'd0) && (int'(hdr) <= CAP);
        if (!exp_valid) begin
            exp_done = 1'b0;
            exp_wl   = 0;
            return;
        end
        cs = hdr;
        foreach (exp_words[i]) begin
            for (int k = 0; k < 4; k++) begin
                stream.push_back(exp_words[i][k*8 +: 8]);
                cs = cs ^ exp_words[i][k*8 +: 8];
            end
        end
        stream.push_back(csum_ok ? cs : (cs ^ 8'h01));
        exp_done = csum_ok;
        exp_wl   = exp_words.size();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gmin, input int gmax, input logic pulse_start);
        int g;
        int n;
        g = (gmax > gmin) ? int'($urandom_range(gmax, gmin)) : gmin;
        ifc.rx_valid = 1'b0;
        for (int i = 0; i < g; i++) begin
            start = pulse_start && (i == 0);
            @(posedge clk); #1;
            start = 1'b0;
        end
        ifc.rx_valid = 1'b1;
        ifc.rx_data  = b;
        n = 0;
        while (!ifc.rx_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) check("rx_ready_timeout", 64'(ifc.rx_ready), 64'd1);
        @(posedge clk); #1;
        ifc.rx_valid = 1'b0;
        ifc.rx_data  = 8'($urandom);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("post_start_core_reset", 64'(core_reset), 64'd1);
        check("post_start_busy", 64'(busy), 64'd1);
        check("post_start_words", 64'(words_loaded), 64'd0);
    endtask

    task automatic run_session(input string tag, input int gmin, input int gmax, input int start_at);
        if (exp_valid) begin
            foreach (exp_words[i]) exp_q.push_back(wr_t'{addr: ADDR_W'(i), data: exp_words[i]});
        end
        do_start();
        foreach (stream[i]) send_byte(stream[i], gmin, gmax, i == start_at);
        @(posedge clk); #1;
        check("pending_writes", 64'(exp_q.size()), 64'd0);
        check("done", 64'(done), 64'(exp_done));
        check("error", 64'(error), 64'(!exp_done));
        check("busy", 64'(busy), 64'd0);
        check("core_reset", 64'(core_reset), 64'(!exp_done));
        check("words_loaded", 64'(words_loaded), 64'(exp_wl));
        check("rx_ready_idle", 64'(ifc.rx_ready), 64'd0);
        if (exp_valid) check("addr_hold", 64'(ifc.imem_addr), 64'(exp_wl - 1));
        $display("session %s: n=%0d done=%0b error=%0b words=%0d", tag, stream[0], done, error, words_loaded);
        exp_q.delete();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_ready"}, 64'(ifc.rx_ready), 64'd0);
        check({tag, "_imem_we"}, 64'(ifc.imem_we), 64'd0);
        check({tag, "_imem_addr"}, 64'(ifc.imem_addr), 64'd0);
        check({tag, "_imem_wdata"}, 64'(ifc.imem_wdata), 64'd0);
        check({tag, "_words"}, 64'(words_loaded), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_error"}, 64'(error), 64'd0);
        check({tag, "_core_reset"}, 64'(core_reset), 64'd1);
        $display("reset check %s: core_reset=%0b busy=%0b", tag, core_reset, busy);
    endtask

    task automatic load_case1(input logic csum_ok);
        exp_words.delete();
        exp_words.push_back(32'hE04F000F);
        exp_words.push_back(32'hE2802005);
        build_session(8'h02, csum_ok);
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        ifc.rx_valid = 1'b0;
        ifc.rx_data  = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("por");
        reset = 1'b0;
        @(posedge clk); #1;

        load_case1(1'b1);
        run_session("case1", 0, 0, -1);

        load_case1(1'b0);
        run_session("case2_badcsum", 0, 0, -1);

        exp_words.delete();
        build_session(8'h00, 1'b1);
        run_session("case3_zero", 0, 0, -1);
        build_session(8'h41, 1'b1);
        run_session("case3_65", 0, 0, -1);

        load_case1(1'b1);
        run_session("case4_gaps", 3, 3, 4);

        // Abort after the sixth byte: word 0 has already been written.
        load_case1(1'b1);
        exp_q.push_back(wr_t'{addr: ADDR_W'(0), data: 32'hE04F000F});
        do_start();
        for (int i = 0; i < 6; i++) send_byte(stream[i], 0, 0, 1'b0);
        reset = 1'b1;
        #1;
        check_reset_values("abort");
        check("abort_pending_writes", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        run_session("case5_restart", 0, 0, -1);

        exp_words.delete();
        for (int i = 0; i < CAP; i++) exp_words.push_back(32'(i));
        build_session(8'(CAP), 1'b1);
        run_session("case6_full", 0, 0, -1);

        for (int s = 0; s < 25; s++) begin
            int r;
            int n;
            r = int'($urandom_range(99, 0));
            exp_words.delete();
            if (r < 15) begin
                build_session(($urandom_range(1, 0) != 0) ? 8'd0 : 8'($urandom_range(255, CAP + 1)), 1'b1);
                run_session("rand_badhdr", 0, 2, -1);
            end else begin
                n = int'($urandom_range(CAP, 1));
                for (int i = 0; i < n; i++) exp_words.push_back($urandom);
                build_session(8'(n), $urandom_range(1, 0) != 0);
                run_session("rand", 0, 2, int'($urandom_range(stream.size() - 1, 1)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
